ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 32-bit words; legal range 4..4096, power of two.
REQ-002 SHALL have parameter WAIT_STATES, default 1, number of Hreadyout-low cycles inserted per OKAY data phase; legal range 0..7.
REQ-003 SHALL have port Hclk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port Hreset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Hsel, input, 1, slave select from address decoder.
REQ-006 SHALL have port Haddr, input, 32, transfer address.
REQ-007 SHALL have port Htrans, input, 2, IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL have port Hwrite, input, 1, 1=write.
REQ-009 SHALL have port Hsize, input, 3, 000=byte, 001=half, 010=word.
REQ-010 SHALL have port Hwdata, input, 32, write data, valid in data phase.
REQ-011 SHALL have port Hready, input, 1, global ready returned by the slave-to-master mux.
REQ-012 SHALL have port Hreadyout, output, 1, this slave's ready, one mux input.
REQ-013 SHALL have port Hrdata, output, 32, read data, one mux input.
REQ-014 SHALL have port Hresp, output, 2, OKAY=00, ERROR=01; encodings 10 and 11 never driven.

Function
REQ-015 SHALL accept an address phase only when Hsel=1, Hready=1 and Htrans[1]=1, registering Haddr, Hwrite and Hsize.
REQ-016 SHALL treat IDLE/BUSY, or Hsel=0 with Hready=1, as no transfer; the following cycle then drives Hreadyout=1 and Hresp=OKAY.
REQ-017 SHALL flag a transfer illegal if Hsize>010, the address is unaligned to Hsize, or Haddr[31:2]>=MEM_DEPTH.
REQ-018 SHALL implement an FSM with states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-019 SHALL make these transitions from IDLE or DATA on an accepted transfer: legal with WAIT_STATES>0 -> WAIT; legal with WAIT_STATES=0 -> DATA; illegal -> ERR1.
REQ-020 SHALL, in WAIT, drive Hreadyout=0 and Hresp=OKAY, and use a 3-bit counter to move to DATA after exactly WAIT_STATES cycles.
REQ-021 SHALL, in DATA, drive Hreadyout=1 and Hresp=OKAY; with no new accepted transfer it goes to IDLE.
REQ-022 SHALL, in ERR1, drive Hreadyout=0 and Hresp=ERROR, then go to ERR2.
REQ-023 SHALL, in ERR2, drive Hreadyout=1 and Hresp=ERROR, perform no memory access, and accept the next address phase as from IDLE.
REQ-024 SHALL, for a write, commit Hwdata at the rising edge ending DATA, enabling only byte lanes selected by Hsize and registered Haddr[1:0] (little-endian).
REQ-025 SHALL, for a read, drive Hrdata in DATA with the full 32-bit word at the registered address; it drives 32'h0 in every other state.
REQ-026 SHALL support back-to-back pipelined transfers: with WAIT_STATES=0, each transfer completes one cycle after its address phase, with no bubble.
REQ-027 SHALL return the new value when a read's data phase follows a write to the same word.
REQ-028 SHALL never update memory on an illegal transfer.
REQ-029 SHALL ignore Hsel, Htrans and Haddr while Hreadyout=0; the pending transfer is unaffected.

Reset
REQ-030 SHALL, while Hreset=1, asynchronously force state IDLE, wait counter 0, registered control 0, Hreadyout=1, Hresp=OKAY and Hrdata=32'h0.
REQ-031 SHALL abandon a transfer in progress at reset without completing its write; memory contents are not reset.
REQ-032 SHALL accept its first address phase in the first cycle after Hreset deasserts.

Structure
REQ-033 SHALL take the htrans_t and hresp_t enums, the HSIZE_* constants and the FSM state enum from shared package ahb_pkg, also used by the decoder and the slave-to-master mux.
REQ-034 SHALL place storage in one sub-module, ahb_sram_array: a MEM_DEPTH x 32 array with a 4-bit byte-enable write port and an asynchronous read port.

Verification
REQ-035 SHALL pass WAIT_STATES=1: write word 32'hCAFEF00D to 0x10, then read 0x10 -> exactly one Hreadyout=0 cycle per transfer; read returns 32'hCAFEF00D with OKAY.
REQ-036 SHALL pass WAIT_STATES=0: NONSEQ write 0x20 then SEQ read 0x20 on consecutive cycles -> Hreadyout stays 1; read returns the written data.
REQ-037 SHALL pass: word preset 32'h0; byte write 8'hA5 at 0x33, then word read 0x30 -> 32'hA5000000.
REQ-038 SHALL pass: word read at 0x402 (unaligned, and out of range at MEM_DEPTH=256) -> Hreadyout 0 then 1, Hresp ERROR for both cycles, Hrdata 0; the next transfer returns OKAY.
REQ-039 SHALL pass: Hreset asserted during WAIT of a write to 0x04 -> outputs at reset values immediately; a subsequent read of 0x04 returns the old contents.
REQ-040 SHALL pass: Htrans=IDLE with Hsel=1 for 3 cycles -> Hreadyout=1, Hresp=OKAY and no memory change.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite types, size codes and byte-lane helpers
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } sram_state_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        return size == HSIZE_BYTE ? 4'b0001 << a :
               size == HSIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] a);
        return size == HSIZE_HALF ? a[0] : size == HSIZE_WORD ? |a : 1'b0;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite bus signals seen by one slave
interface ahb_sram_slave_if;
    import ahb_pkg::*;

    logic        Hsel;
    logic [31:0] Haddr;
    htrans_t     Htrans;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [31:0] Hwdata;
    logic        Hready;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    hresp_t      Hresp;

    modport master (
        output Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hready,
        input  Hreadyout, Hrdata, Hresp
    );

    modport slave (
        input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hready,
        output Hreadyout, Hrdata, Hresp
    );

endinterface

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: word-wide storage with byte-enable write and asynchronous read
module ahb_sram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // write only the enabled byte lanes; contents survive reset on purpose
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++)
            if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input logic             Hclk,
    input logic             Hreset,
    ahb_sram_slave_if.slave bus
);

    localparam int AW = $clog2(MEM_DEPTH);

    sram_state_t   state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
    logic          open_ph, accept, illegal;
    logic [31:0]   rdata;
    logic [3:0]    be;

    // a new address phase can only land while this slave is showing ready
    assign open_ph = state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2;
    assign accept  = open_ph && bus.Hsel && bus.Hready &&
                     (bus.Htrans == HT_NONSEQ || bus.Htrans == HT_SEQ);
    assign illegal = bus.Hsize > HSIZE_WORD || misaligned(bus.Hsize, bus.Haddr[1:0]) ||
                     bus.Haddr[31:2] >= 30'(MEM_DEPTH);

    // state, wait counter and registered address-phase control
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // next state: stall through WAIT/ERR1, otherwise follow the accepted transfer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'(WAIT_STATES - 1)) state_d = ST_DATA;
                else cnt_d = cnt_q + 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            addr_d  = bus.Haddr[AW+1:0];
            write_d = bus.Hwrite;
            size_d  = bus.Hsize;
            cnt_d   = '0;
            state_d = illegal ? ST_ERR1 : (WAIT_STATES > 0 ? ST_WAIT : ST_DATA);
        end
    end

    // illegal transfers never reach DATA, so they can never write
    assign be = (state_q == ST_DATA && write_q) ? byte_en(size_q, addr_q[1:0]) : 4'b0000;

    ahb_sram_array #(.DEPTH(MEM_DEPTH)) u_array (
        .clk_i  (Hclk),
        .be_i   (be),
        .waddr_i(addr_q[AW+1:2]),
        .wdata_i(bus.Hwdata),
        .raddr_i(addr_q[AW+1:2]),
        .rdata_o(rdata)
    );

    assign bus.Hreadyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
    assign bus.Hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.Hrdata    = (state_q == ST_DATA && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: scoreboard bench driving a zero-wait and a one-wait SRAM slave
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    logic        sel   [2];
    htrans_t     trans [2];
    logic        write [2];
    logic [31:0] addr  [2];
    logic [2:0]  size  [2];
    logic [31:0] wdata [2];
    logic        rdy   [2];
    logic [31:0] rd    [2];
    logic [1:0]  rsp   [2];

    logic [31:0] nxt_wd  [2];
    logic [31:0] last_rd [2];
    logic        pend    [2];
    int          waits   [2];
    logic [31:0] ref_mem [2][256];
    exp_t        sb      [2][$];

    ahb_sram_slave_if b0 ();
    ahb_sram_slave_if b1 ();

    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (.Hclk(clk), .Hreset(rst), .bus(b0));
    ahb_sram_slave #(.MEM_DEPTH(256), .WAIT_STATES(1)) u_ws1 (.Hclk(clk), .Hreset(rst), .bus(b1));

    assign b0.Hsel = sel[0];
    assign b0.Htrans = trans[0];
    assign b0.Hwrite = write[0];
    assign b0.Haddr = addr[0];
    assign b0.Hsize = size[0];
    assign b0.Hwdata = wdata[0];
    assign b0.Hready = b0.Hreadyout;
    assign rdy[0] = b0.Hreadyout;
    assign rd[0] = b0.Hrdata;
    assign rsp[0] = b0.Hresp;

    assign b1.Hsel = sel[1];
    assign b1.Htrans = trans[1];
    assign b1.Hwrite = write[1];
    assign b1.Haddr = addr[1];
    assign b1.Hsize = size[1];
    assign b1.Hwdata = wdata[1];
    assign b1.Hready = b1.Hreadyout;
    assign rdy[1] = b1.Hreadyout;
    assign rd[1] = b1.Hrdata;
    assign rsp[1] = b1.Hresp;

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one bus cycle: present an address phase (or idle) and carry the previous write's data
    task automatic step(input int d, input htrans_t tr, input logic w, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        logic ok;
        int   n;
        wdata[d] = nxt_wd[d];
        sel[d]   = tr[1];
        trans[d] = tr;
        write[d] = w;
        addr[d]  = a;
        size[d]  = sz;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[d] && n < 20);
        chk($sformatf("d%0d_ready_a%h", d, a), 32'(rdy[d]), 32'd1);
        @(posedge clk);
        #1;
        if (tr[1]) begin
            ok = sz <= 3'd2 && !(sz == 3'd1 && a[0]) && !(sz == 3'd2 && a[1:0] != 2'b00) &&
                 a[31:2] < 30'd256;
            e.resp  = ok ? 2'b00 : 2'b01;
            e.waits = ok ? d : 1;
            e.rdata = 32'h0;
            if (ok && w)
                for (int i = 0; i < 4; i++)
                    if (sz == 3'd2 || (sz == 3'd1 && (i / 2) == int'(a[1])) ||
                        (sz == 3'd0 && i == int'(a[1:0])))
                        ref_mem[d][a[9:2]][8*i +: 8] = wd[8*i +: 8];
            if (ok && !w) e.rdata = ref_mem[d][a[9:2]];
            sb[d].push_back(e);
            nxt_wd[d] = wd;
        end
    endtask

    // monitor: stall cycles must show the pending response; completion pops the scoreboard
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pend[d] = 1'b0;
                sb[d].delete();
            end else begin
                if (pend[d]) begin
                    if (!rdy[d]) begin
                        waits[d]++;
                        chk($sformatf("d%0d_stall_rdata", d), rd[d], 32'h0);
                        if (sb[d].size() > 0)
                            chk($sformatf("d%0d_stall_resp", d), 32'(rsp[d]), 32'(sb[d][0].resp));
                    end else if (sb[d].size() == 0) begin
                        chk($sformatf("d%0d_sb_size", d), 32'(sb[d].size()), 32'd1);
                        pend[d] = 1'b0;
                    end else begin
                        exp_t e;
                        e = sb[d].pop_front();
                        chk($sformatf("d%0d_rdata", d), rd[d], e.rdata);
                        chk($sformatf("d%0d_resp", d), 32'(rsp[d]), 32'(e.resp));
                        chk($sformatf("d%0d_waits", d), 32'(waits[d]), 32'(e.waits));
                        last_rd[d] = rd[d];
                        pend[d] = 1'b0;
                    end
                end
                if (rdy[d] && sel[d] && trans[d][1]) begin
                    pend[d]  = 1'b1;
                    waits[d] = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] saved;
        for (int d = 0; d < 2; d++) begin
            sel[d] = 1'b0; trans[d] = HT_IDLE; write[d] = 1'b0; addr[d] = '0;
            size[d] = '0; wdata[d] = '0; nxt_wd[d] = '0; last_rd[d] = '0;
            pend[d] = 1'b0; waits[d] = 0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_ready", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("d%0d_rst_resp", d), 32'(rsp[d]), 32'd0);
            chk($sformatf("d%0d_rst_rdata", d), rd[d], 32'h0);
        end
        rst = 1'b0;

        // one wait state: write then read the same word, read presented during the write's stall
        step(1, HT_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hCAFEF00D);
        step(1, HT_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
        step(1, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("ws1_readback", last_rd[1], 32'hCAFEF00D);

        // zero wait states: back-to-back write/read to the same word
        step(0, HT_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'h13572468);
        step(0, HT_SEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
        step(0, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("ws0_readback", last_rd[0], 32'h13572468);
        step(0, HT_NONSEQ, 1'b1, 32'h24, HSIZE_WORD, 32'h01020304);
        step(0, HT_SEQ, 1'b1, 32'h28, HSIZE_WORD, 32'hF0E0D0C0);
        step(0, HT_NONSEQ, 1'b1, 32'h26, HSIZE_HALF, 32'h77660000);
        step(0, HT_NONSEQ, 1'b0, 32'h24, HSIZE_WORD, 32'h0);
        step(0, HT_SEQ, 1'b0, 32'h28, HSIZE_WORD, 32'h0);
        step(0, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("ws0_pipe_last", last_rd[0], 32'hF0E0D0C0);

        // byte and halfword lane selection
        step(1, HT_NONSEQ, 1'b1, 32'h30, HSIZE_WORD, 32'h0);
        step(1, HT_NONSEQ, 1'b1, 32'h33, HSIZE_BYTE, 32'hA5A5A5A5);
        step(1, HT_NONSEQ, 1'b0, 32'h30, HSIZE_WORD, 32'h0);
        step(1, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("byte_lane3", last_rd[1], 32'hA5000000);
        step(1, HT_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'h11223344);
        step(1, HT_NONSEQ, 1'b1, 32'h42, HSIZE_HALF, 32'hBEEFBEEF);
        step(1, HT_NONSEQ, 1'b1, 32'h40, HSIZE_BYTE, 32'hAAAAAAAA);
        step(1, HT_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0);
        step(1, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("half_byte_mix", last_rd[1], 32'hBEEF33AA);

        // illegal transfers: ERROR for two cycles, no memory update, next transfer OKAY
        step(1, HT_NONSEQ, 1'b0, 32'h402, HSIZE_WORD, 32'h0);
        step(1, HT_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
        step(1, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("after_error", last_rd[1], 32'hCAFEF00D);
        step(1, HT_NONSEQ, 1'b1, 32'h0, HSIZE_WORD, 32'h55AA55AA);
        step(1, HT_NONSEQ, 1'b1, 32'h400, HSIZE_WORD, 32'hFFFFFFFF);
        step(1, HT_NONSEQ, 1'b1, 32'h31, HSIZE_HALF, 32'hFFFFFFFF);
        step(1, HT_NONSEQ, 1'b1, 32'h0, 3'b011, 32'hFFFFFFFF);
        step(1, HT_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        step(1, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("illegal_no_write", last_rd[1], 32'h55AA55AA);
        step(0, HT_NONSEQ, 1'b1, 32'h1FE, HSIZE_WORD, 32'hFFFFFFFF);
        step(0, HT_NONSEQ, 1'b0, 32'h24, HSIZE_WORD, 32'h0);
        step(0, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("ws0_after_error", last_rd[0], 32'h77660304);

        // IDLE/BUSY with select, then NONSEQ without select: nothing is a transfer
        write[1] = 1'b1; addr[1] = 32'h30; size[1] = HSIZE_WORD; wdata[1] = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            sel[1]   = c < 4;
            trans[1] = c < 3 ? HT_IDLE : c == 3 ? HT_BUSY : HT_NONSEQ;
            @(negedge clk);
            chk($sformatf("notx%0d_ready", c), 32'(rdy[1]), 32'd1);
            chk($sformatf("notx%0d_resp", c), 32'(rsp[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        step(1, HT_NONSEQ, 1'b0, 32'h30, HSIZE_WORD, 32'h0);
        step(1, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("notx_no_write", last_rd[1], 32'hA5000000);

        // reset in the middle of a stalled write abandons it
        step(1, HT_NONSEQ, 1'b1, 32'h04, HSIZE_WORD, 32'h11112222);
        step(1, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        saved = ref_mem[1][1];
        step(1, HT_NONSEQ, 1'b1, 32'h04, HSIZE_WORD, 32'hDEADBEEF);
        sel[1] = 1'b0; trans[1] = HT_IDLE; wdata[1] = 32'hDEADBEEF;
        #2;
        chk("pre_rst_stall", 32'(rdy[1]), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_ready", 32'(rdy[1]), 32'd1);
        chk("async_rst_resp", 32'(rsp[1]), 32'd0);
        chk("async_rst_rdata", rd[1], 32'h0);
        ref_mem[1][1] = saved;
        nxt_wd[1] = 32'h0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, HT_NONSEQ, 1'b0, 32'h04, HSIZE_WORD, 32'h0);
        step(1, HT_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        chk("rst_old_contents", last_rd[1], 32'h11112222);

        repeat (2) @(posedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d_sb_drained", d), 32'(sb[d].size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
